muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two operand read-data values plus the destination register index. It produces a tagged result for the writeback path, which drives the register file write port (data, register index, write enable). Sequential shift-add and restoring-divide datapath with a start/busy/valid handshake, so the pipeline stalls while it runs.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose: sequential shift-add multiplier and restoring divider for the
// execute stage. An operation is accepted from IDLE, iterates once per cycle
// in RUN, and presents a one-cycle tagged result in DONE for writeback.
// Divide-by-zero and signed overflow bypass RUN with a precomputed result.
//
// Ports:
//   i_clk, i_reset         clock; synchronous active-high reset
//   i_start                request, sampled only in IDLE
//   i_funct3               RV32M operation select
//   i_rs1_data, i_rs2_data operands, registered at accept
//   i_rd                   destination tag, registered at accept
//   i_flush                abort in-flight operation (wins over i_start)
//   o_busy                 high whenever not IDLE
//   o_valid                one-cycle result strobe
//   o_result               result; holds the last delivered value otherwise
//   o_rd                   tag captured at accept
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_a;        // multiplier (low product half) / dividend becoming quotient
  logic [XLEN-1:0] r_b;        // multiplicand / divisor magnitude
  logic [XLEN-1:0] r_hi;       // high product half / partial remainder
  logic            r_neg;      // negate the selected result at the end
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_pending;  // result presented in DONE
  logic [XLEN-1:0] r_hold;     // last delivered result
  logic            w_valid;

  // Operand conditioning at accept
  logic            w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_special_res;

  assign w_a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                      (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
  assign w_b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
                      (i_funct3 == 3'b110);
  assign w_sa       = w_a_signed && i_rs1_data[XLEN-1];
  assign w_sb       = w_b_signed && i_rs2_data[XLEN-1];
  assign w_abs_a    = w_sa ? -i_rs1_data : i_rs1_data;
  assign w_abs_b    = w_sb ? -i_rs2_data : i_rs2_data;
  // Remainder follows the dividend sign; product and quotient follow sign mismatch
  assign w_neg      = (i_funct3[2] && i_funct3[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_div_zero = i_funct3[2] && (i_rs2_data == '0);
  assign w_ovf      = i_funct3[2] && !i_funct3[0] &&
                      (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (i_rs2_data == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_special_res = w_div_zero ? (i_funct3[1] ? i_rs1_data : '1)
                                    : (i_funct3[1] ? '0 : i_rs1_data);
  assign w_accept   = (r_state == S_IDLE) && i_start && !i_flush;

  // One iteration of either datapath
  logic [XLEN:0]   w_sum, w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub, w_hi_nxt, w_a_nxt;

  assign w_sum   = {1'b0, r_hi} + (r_a[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_a[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  // When w_ge holds the true difference is below the divisor, so XLEN bits suffice
  assign w_sub   = w_shift[XLEN-1:0] - r_b;

  always_comb begin
    w_hi_nxt = w_sum[XLEN:1];
    w_a_nxt  = {w_sum[0], r_a[XLEN-1:1]};
    if (r_funct3[2]) begin
      w_hi_nxt = w_ge ? w_sub : w_shift[XLEN-1:0];
      w_a_nxt  = {r_a[XLEN-2:0], w_ge};
    end
  end

  // Sign correction applied to the values produced by the final iteration
  logic [2*XLEN-1:0] w_prod, w_prod_c;
  logic [XLEN-1:0]   w_quo_c, w_rem_c, w_final;

  assign w_prod   = {w_hi_nxt, w_a_nxt};
  assign w_prod_c = r_neg ? -w_prod : w_prod;
  assign w_quo_c  = r_neg ? -w_a_nxt : w_a_nxt;
  assign w_rem_c  = r_neg ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    w_final = w_prod_c[XLEN-1:0];
    case (r_funct3)
      3'b000:                 w_final = w_prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo_c;
      default:                w_final = w_rem_c;
    endcase
  end

  // FSM
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_RUN;
      S_RUN: begin
        if (i_flush)            w_state_nxt = S_IDLE;
        else if (r_cnt == '0)   w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_valid     = !i_flush;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_funct3  <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_funct3 <= i_funct3;
          r_rd     <= i_rd;
          r_a      <= w_abs_a;
          r_b      <= w_abs_b;
          r_hi     <= '0;
          r_neg    <= w_neg;
          r_cnt    <= CW'(ITERS - 1);
          if (w_special) r_pending <= w_special_res;
        end
        S_RUN: if (!i_flush) begin
          r_hi  <= w_hi_nxt;
          r_a   <= w_a_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_pending <= w_final;
        end
        S_DONE: if (!i_flush) r_hold <= r_pending;
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_valid  = w_valid;
  // A flushed DONE cycle must not expose the abandoned result
  assign o_result = w_valid ? r_pending : r_hold;
  assign o_rd     = r_rd;

endmodule
